// File: rtl/gray_code_converter_pipe.sv
// Pipelined binary<->Gray converter with valid/ready backpressure and per-item mode select.
// Optional macro GRAY_STEP_CHECK_EN adds step_err, flagging output Gray steps that are not single-bit.
module gray_code_converter_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] m;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  d [STAGES];
    logic [WIDTH-1:0]  conv;

    // Gray->bin is a running XOR from the MSB downwards.
    always_comb begin
        logic acc;
        conv = '0;
        acc  = 1'b0;
        if (!in_mode) begin
            conv = in_data ^ (in_data >> 1);
        end else begin
            acc = in_data[WIDTH-1];
            conv[WIDTH-1] = acc;
            for (int i = WIDTH - 2; i >= 0; i--) begin
                acc     = acc ^ in_data[i];
                conv[i] = acc;
            end
        end
    end

    // A stage may move when out_ready is high or any stage from it to the end holds a bubble.
    always_comb begin
        logic full_run;
        adv      = '0;
        full_run = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            full_run = 1'b1;
            for (int j = k; j < STAGES; j++) begin
                full_run = full_run & v[j];
            end
            adv[k] = out_ready || !full_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            m <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    m[0] <= in_mode;
                    d[0] <= conv;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        m[k] <= m[k-1];
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign out_mode  = m[STAGES-1];
    assign out_data  = d[STAGES-1];

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] g [STAGES];
    logic [WIDTH-1:0] last_gray;
    logic             seen;

    // The Gray-domain value of each item rides alongside it: the result for bin->Gray, the input otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                g[k] <= '0;
            end
        end else begin
            if (adv[0] && in_valid) begin
                g[0] <= in_mode ? in_data : conv;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k] && v[k-1]) begin
                    g[k] <= g[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gray <= '0;
            seen      <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            step_err <= 1'b0;
            if (out_valid && out_ready) begin
                step_err  <= seen && ($countones(g[STAGES-1] ^ last_gray) != 1);
                last_gray <= g[STAGES-1];
                seen      <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Scoreboard bench for gray_code_converter_pipe (WIDTH=4/STAGES=2 main DUT, WIDTH=1/STAGES=1 corner DUT).
module tb_gray_code_converter_pipe;

    typedef struct packed {
        logic       mode;
        logic [3:0] din;
        logic [3:0] exp;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [3:0] in_data, out_data;
    logic       w1_in_valid, w1_in_ready, w1_in_mode, w1_out_valid, w1_out_mode;
    logic [0:0] w1_in_data, w1_out_data;
    logic       step_err, w1_step_err;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_acc = 0;
    int    n_out = 0;
    int    first_acc = -1;
    int    first_out = -1;
    int    last_out = -1;
    int    n_step_err = 0;
    logic       exp_err_pending = 1'b0;
    logic       model_seen = 1'b0;
    logic [3:0] model_last = 4'h0;

    always #5 clk = ~clk;

    gray_code_converter_pipe #(.WIDTH(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data)
`ifdef GRAY_STEP_CHECK_EN
        , .step_err(step_err)
`endif
    );

    gray_code_converter_pipe #(.WIDTH(1), .STAGES(1)) dut_w1 (
        .clk(clk), .rst(rst),
        .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_mode(w1_in_mode), .in_data(w1_in_data),
        .out_valid(w1_out_valid), .out_ready(1'b1), .out_mode(w1_out_mode), .out_data(w1_out_data)
`ifdef GRAY_STEP_CHECK_EN
        , .step_err(w1_step_err)
`endif
    );

`ifndef GRAY_STEP_CHECK_EN
    assign step_err    = 1'b0;
    assign w1_step_err = 1'b0;
`endif

    function automatic logic [3:0] ref_conv(input logic mode, input logic [3:0] x);
        logic [3:0] r;
        if (!mode) return x ^ (x >> 1);
        for (int i = 0; i < 4; i++) r[i] = ^(x >> i);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic mode, input logic [3:0] data);
        in_valid = v;
        in_mode  = mode;
        in_data  = data;
    endtask

    // Sample at the falling edge, then cross the rising edge and settle 1 time unit past it.
    task automatic tick();
        item_t it;
        @(negedge clk);
`ifdef GRAY_STEP_CHECK_EN
        checkOutput("step_err", step_err, exp_err_pending);
        if (step_err === 1'b1) n_step_err++;
        exp_err_pending = 1'b0;
`endif
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 1, 0);
            end else begin
                it = sb.pop_front();
                checkOutput("out_data", out_data, it.exp);
                checkOutput("out_mode", out_mode, it.mode);
`ifdef GRAY_STEP_CHECK_EN
                begin
                    logic [3:0] gv;
                    gv = it.mode ? it.din : it.exp;
                    exp_err_pending = model_seen && ($countones(gv ^ model_last) != 1);
                    model_last = gv;
                    model_seen = 1'b1;
                end
`endif
            end
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (in_valid && in_ready) begin
            it.mode = in_mode;
            it.din  = in_data;
            it.exp  = ref_conv(in_mode, in_data);
            sb.push_back(it);
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
            exp_err_pending = 1'b0;
            model_seen = 1'b0;
            model_last = 4'h0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        applyStimulus(1'b0, 1'b0, 4'h0);
        while (sb.size() > 0 && budget < 50) begin
            tick();
            budget++;
        end
        checkOutput("drain_left", sb.size(), 0);
    endtask

    initial begin
        int base;
        int budget;
        int out_before;
        logic [3:0] held;
        logic [3:0] w1_vecs;

        rst = 1'b1;
        out_ready = 1'b1;
        w1_in_valid = 1'b0;
        w1_in_mode = 1'b0;
        w1_in_data = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_mode", out_mode, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] bin->Gray stream 0..15");
        first_acc = -1;
        first_out = -1;
        n_out = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'(i));
            tick();
        end
        drain();
        checkOutput("latency", first_out - first_acc, 2);
        checkOutput("no_gaps", last_out - first_out, 15);
        checkOutput("stream_count", n_out, 16);
        checkOutput("idle_out_valid", out_valid, 0);

        $display("[TB] Gray->bin items");
        applyStimulus(1'b1, 1'b1, 4'hB); tick();
        applyStimulus(1'b1, 1'b1, 4'h8); tick();
        applyStimulus(1'b1, 1'b1, 4'hF); tick();
        drain();

        $display("[TB] alternating modes");
        applyStimulus(1'b1, 1'b0, 4'h5); tick();
        applyStimulus(1'b1, 1'b1, 4'h7); tick();
        applyStimulus(1'b1, 1'b0, 4'hF); tick();
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        base = n_acc;
        for (int t = 0; t < 4; t++) begin
            applyStimulus(1'b1, 1'b0, 4'(1 + n_acc - base));
            tick();
        end
        checkOutput("full_accepted", n_acc - base, 2);
        checkOutput("full_in_ready", in_ready, 0);
        held = out_data;
        tick();
        checkOutput("held_out_valid", out_valid, 1);
        checkOutput("held_out_data", out_data, held);
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", in_ready, 1);
        budget = 0;
        while (n_acc - base < 4 && budget < 10) begin
            applyStimulus(1'b1, 1'b0, 4'(1 + n_acc - base));
            tick();
            budget++;
        end
        checkOutput("release_accepted", n_acc - base, 4);
        drain();

        $display("[TB] reset flush");
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h6); tick();
        applyStimulus(1'b1, 1'b0, 4'h9); tick();
        applyStimulus(1'b0, 1'b0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_out_data", out_data, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        out_before = n_out;
        for (int t = 0; t < 4; t++) tick();
        checkOutput("flush_no_output", n_out - out_before, 0);

        $display("[TB] WIDTH=1 corner");
        w1_vecs = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            w1_in_valid = 1'b1;
            w1_in_mode  = k[1];
            w1_in_data  = w1_vecs[k];
            tick();
            checkOutput("w1_out_valid", w1_out_valid, 1);
            checkOutput("w1_out_data", w1_out_data, w1_vecs[k]);
            checkOutput("w1_out_mode", w1_out_mode, k[1]);
        end
        w1_in_valid = 1'b0;
        tick();

`ifdef GRAY_STEP_CHECK_EN
        $display("[TB] Gray step check");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_step_err = 0;
        applyStimulus(1'b1, 1'b0, 4'h0); tick();
        applyStimulus(1'b1, 1'b0, 4'h1); tick();
        applyStimulus(1'b1, 1'b0, 4'h2); tick();
        applyStimulus(1'b1, 1'b0, 4'h3); tick();
        applyStimulus(1'b1, 1'b0, 4'h0); tick();
        applyStimulus(1'b1, 1'b0, 4'h5); tick();
        drain();
        tick();
        tick();
        checkOutput("step_err_count", n_step_err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
